// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with per-key debounce and a
// one-hot press pulse for the downstream slot-management stage.
// Optional build macro: KEY_REPEAT_EN (auto-repeat of a single held key).
module keypad_scan #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 8,
    parameter int REPEAT_DELAY   = 500,
    parameter int REPEAT_RATE    = 100
) (
    input  logic        clk,
    input  logic        rst_n,      // active-high synchronous reset
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    output logic [15:0] key_press,
    output logic [15:0] key_edge,
    output logic        scan_tick
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]       DEB_LAST = 4'(DEBOUNCE_SCANS - 1);

    if (DEBOUNCE_SCANS < 2 || DEBOUNCE_SCANS > 15 ||
        REPEAT_RATE < 1 || REPEAT_RATE > REPEAT_DELAY) begin : g_bad_params
        $error("keypad_scan: parameter out of range");
    end

    typedef enum logic [1:0] {COL0, COL1, COL2, COL3} col_state_e;

    col_state_e        state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [3:0]        row_meta_q, row_sync_q;
    logic [15:0]       raw_q, raw_d;
    logic              scan_tick_q, scan_tick_d;
    logic [15:0][3:0]  cnt_q, cnt_d;
    logic [15:0]       key_press_q, key_press_d;
    logic [15:0]       press_prev_q;
    logic [15:0]       key_edge_q, key_edge_d;
    logic              sample;

`ifdef KEY_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_DELAY + 1);
    localparam logic [REP_W-1:0] REP_LAST   = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REPEAT_DELAY - REPEAT_RATE);

    logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
    logic              rep_fire_q, rep_fire_d;
`endif

    assign sample    = (div_q == DIV_LAST);
    assign key_press = key_press_q;
    assign key_edge  = key_edge_q;
    assign scan_tick = scan_tick_q;

    // Column FSM, divider and raw matrix sampling at the last divider count.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q + DIV_W'(1);
        raw_d       = raw_q;
        scan_tick_d = 1'b0;
        col_out     = ~(4'b0001 << state_q);
        if (sample) begin
            div_d = '0;
            for (int unsigned r = 0; r < 4; r++) begin
                raw_d[{r[1:0], state_q}] = ~row_sync_q[r];
            end
            scan_tick_d = (state_q == COL3);
            case (state_q)
                COL0:    state_d = COL1;
                COL1:    state_d = COL2;
                COL2:    state_d = COL3;
                default: state_d = COL0;
            endcase
        end
    end

    // Per-key debounce, evaluated once per completed scan.
    always_comb begin
        key_press_d = key_press_q;
        cnt_d       = cnt_q;
        if (scan_tick_q) begin
            for (int unsigned k = 0; k < 16; k++) begin
                if (raw_q[k[3:0]] != key_press_q[k[3:0]]) begin
                    if (cnt_q[k[3:0]] == DEB_LAST) begin
                        key_press_d[k[3:0]] = ~key_press_q[k[3:0]];
                        cnt_d[k[3:0]]       = '0;
                    end else begin
                        cnt_d[k[3:0]] = cnt_q[k[3:0]] + 4'd1;
                    end
                end else begin
                    cnt_d[k[3:0]] = '0;
                end
            end
        end
    end

`ifdef KEY_REPEAT_EN
    // Repeat timer: runs only while one key is held and the level is steady;
    // the fire flag is suppressed if the level is about to change this cycle.
    always_comb begin
        rep_cnt_d  = rep_cnt_q;
        rep_fire_d = 1'b0;
        if (key_press_q != press_prev_q || !$onehot(key_press_q)) begin
            rep_cnt_d = '0;
        end else if (scan_tick_q) begin
            if (rep_cnt_q == REP_LAST) begin
                rep_fire_d = (key_press_d == key_press_q);
                rep_cnt_d  = REP_RELOAD;
            end else begin
                rep_cnt_d = rep_cnt_q + REP_W'(1);
            end
        end
    end
`endif

    // Press pulse: rising bits of key_press, issued only when exactly one key is down.
    always_comb begin
        key_edge_d = $onehot(key_press_q) ? (key_press_q & ~press_prev_q) : '0;
`ifdef KEY_REPEAT_EN
        if (rep_fire_q && $onehot(key_press_q) && key_press_q == press_prev_q) begin
            key_edge_d = key_press_q;
        end
`endif
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q      <= COL0;
            div_q        <= '0;
            row_meta_q   <= '1;
            row_sync_q   <= '1;
            raw_q        <= '0;
            scan_tick_q  <= 1'b0;
            cnt_q        <= '0;
            key_press_q  <= '0;
            press_prev_q <= '0;
            key_edge_q   <= '0;
`ifdef KEY_REPEAT_EN
            rep_cnt_q    <= '0;
            rep_fire_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            row_meta_q   <= row_in;
            row_sync_q   <= row_meta_q;
            raw_q        <= raw_d;
            scan_tick_q  <= scan_tick_d;
            cnt_q        <= cnt_d;
            key_press_q  <= key_press_d;
            press_prev_q <= key_press_q;
            key_edge_q   <= key_edge_d;
`ifdef KEY_REPEAT_EN
            rep_cnt_q    <= rep_cnt_d;
            rep_fire_q   <= rep_fire_d;
`endif
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed testbench for keypad_scan (SCAN_DIV=4, DEBOUNCE_SCANS=3,
// REPEAT_DELAY=5, REPEAT_RATE=2). Repeat expectations follow KEY_REPEAT_EN.
module tb_keypad_scan;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [15:0] key_press;
    logic [15:0] key_edge;
    logic        scan_tick;
    logic [15:0] held = '0;

    int checks = 0;
    int errors = 0;

    keypad_scan #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (3),
        .REPEAT_DELAY   (5),
        .REPEAT_RATE    (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_press (key_press),
        .key_edge  (key_edge),
        .scan_tick (scan_tick)
    );

    always #5 clk = ~clk;

    // Ideal keypad: a row reads 0 when a held key sits on the driven column.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row_in[r] = 1'b1;
            for (int c = 0; c < 4; c++) begin
                if (held[4*r+c] && !col_out[c]) row_in[r] = 1'b0;
            end
        end
    end

    // Leaves the bench at the negedge of the first cycle after the reset edge.
    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (n) @(negedge clk);
        rst_n = 1'b0;
    endtask

    // Advance n scan ticks, ending on the negedge where scan_tick is high;
    // counts non-zero key_edge samples seen on the way.
    task automatic wait_ticks(input int n, output int edges);
        edges = 0;
        for (int i = 0; i < n; i++) begin
            int t = 0;
            do begin
                @(negedge clk);
                t++;
                if (key_edge !== 16'h0) edges++;
            end while (scan_tick !== 1'b1 && t < 40);
            checks++;
            if (scan_tick !== 1'b1) begin
                errors++;
                $display("FAIL scan_tick_timeout: no scan_tick within %0d clk", t);
            end
        end
    endtask

    task automatic release_all(input string name);
        int e;
        held = '0;
        wait_ticks(5, e);
        checks++;
        if (e !== 0) begin
            errors++;
            $display("FAIL %s_release_edges: got %0d edges, want 0", name, e);
        end
        checks++;
        if (key_press !== 16'h0) begin
            errors++;
            $display("FAIL %s_release_press: got %h, want 0000", name, key_press);
        end
    endtask

    task automatic test_reset;
        logic [3:0] exp_col;
        logic       exp_tick;
        do_reset(3);
        for (int c = 0; c <= 160; c++) begin
            if (c != 0) @(negedge clk);
            exp_col  = ~(4'b0001 << ((c / 4) % 4));
            exp_tick = (c != 0) && (c % 16 == 0);
            checks++;
            if (col_out !== exp_col) begin
                errors++;
                $display("FAIL reset_col c=%0d: got %b, want %b", c, col_out, exp_col);
            end
            checks++;
            if (scan_tick !== exp_tick) begin
                errors++;
                $display("FAIL reset_tick c=%0d: got %b, want %b", c, scan_tick, exp_tick);
            end
            checks++;
            if (key_press !== 16'h0 || key_edge !== 16'h0) begin
                errors++;
                $display("FAIL reset_idle c=%0d: press %h edge %h, want 0000 0000",
                         c, key_press, key_edge);
            end
        end
    endtask

    task automatic test_press;
        int e;
        wait_ticks(1, e);
        held = 16'h0020;
        wait_ticks(2, e);
        checks++;
        if (key_press !== 16'h0 || e !== 0) begin
            errors++;
            $display("FAIL press_early: press %h edges %0d, want 0000 0", key_press, e);
        end
        wait_ticks(1, e);
        @(negedge clk);
        checks++;
        if (key_press !== 16'h0020 || key_edge !== 16'h0) begin
            errors++;
            $display("FAIL press_level: press %h edge %h, want 0020 0000", key_press, key_edge);
        end
        @(negedge clk);
        checks++;
        if (key_edge !== 16'h0020) begin
            errors++;
            $display("FAIL press_edge: got %h, want 0020", key_edge);
        end
        @(negedge clk);
        checks++;
        if (key_edge !== 16'h0) begin
            errors++;
            $display("FAIL press_edge_width: got %h, want 0000", key_edge);
        end
        wait_ticks(3, e);
        checks++;
        if (e !== 0 || key_press !== 16'h0020) begin
            errors++;
            $display("FAIL press_hold: edges %0d press %h, want 0 0020", e, key_press);
        end
        release_all("press");
    endtask

    task automatic test_bounce;
        int e;
        int total = 0;
        wait_ticks(1, e);
        for (int i = 0; i < 6; i++) begin
            held = (i % 2 == 0) ? 16'h0020 : 16'h0000;
            wait_ticks(1, e);
            total += e;
        end
        held = 16'h0020;
        wait_ticks(3, e);
        total += e;
        checks++;
        if (total !== 0 || key_press !== 16'h0) begin
            errors++;
            $display("FAIL bounce_quiet: edges %0d press %h, want 0 0000", total, key_press);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (key_edge !== 16'h0020 || key_press !== 16'h0020) begin
            errors++;
            $display("FAIL bounce_edge: edge %h press %h, want 0020 0020", key_edge, key_press);
        end
        @(negedge clk);
        checks++;
        if (key_edge !== 16'h0) begin
            errors++;
            $display("FAIL bounce_edge_width: got %h, want 0000", key_edge);
        end
        release_all("bounce");
    endtask

    task automatic test_multi_key;
        int e;
        wait_ticks(1, e);
        held = 16'h0004;
        wait_ticks(3, e);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (key_edge !== 16'h0004 || key_press !== 16'h0004) begin
            errors++;
            $display("FAIL multi_first_edge: edge %h press %h, want 0004 0004", key_edge, key_press);
        end
        held = 16'h0204;
        wait_ticks(5, e);
        checks++;
        if (e !== 0) begin
            errors++;
            $display("FAIL multi_second_edge: got %0d edges, want 0", e);
        end
        checks++;
        if (key_press !== 16'h0204) begin
            errors++;
            $display("FAIL multi_level: got %h, want 0204", key_press);
        end
        release_all("multi");
    endtask

    task automatic test_reset_mid;
        int e;
        logic [15:0] exp_edge;
        wait_ticks(1, e);
        held = 16'h0020;
        wait_ticks(2, e);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        checks++;
        if (col_out !== 4'b1110 || key_press !== 16'h0 || key_edge !== 16'h0 ||
            scan_tick !== 1'b0) begin
            errors++;
            $display("FAIL midreset_values: col %b press %h edge %h tick %b, want 1110 0000 0000 0",
                     col_out, key_press, key_edge, scan_tick);
        end
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            exp_edge = (c == 50) ? 16'h0020 : 16'h0000;
            checks++;
            if (key_edge !== exp_edge) begin
                errors++;
                $display("FAIL midreset_edge c=%0d: got %h, want %h", c, key_edge, exp_edge);
            end
        end
        checks++;
        if (key_press !== 16'h0020) begin
            errors++;
            $display("FAIL midreset_level: got %h, want 0020", key_press);
        end
        release_all("midreset");
    endtask

    task automatic test_repeat;
        int e;
        logic hit;
        logic [15:0] exp_edge;
        wait_ticks(1, e);
        held = 16'h0080;
        for (int c = 1; c <= 320; c++) begin
            @(negedge clk);
`ifdef KEY_REPEAT_EN
            hit = (c == 50) || (c == 130) || (c == 162) || (c == 194) || (c == 226);
`else
            hit = (c == 50);
`endif
            exp_edge = hit ? 16'h0080 : 16'h0000;
            checks++;
            if (key_edge !== exp_edge) begin
                errors++;
                $display("FAIL repeat_edge c=%0d: got %h, want %h", c, key_edge, exp_edge);
            end
            if (c == 192) held = '0;
        end
        checks++;
        if (key_press !== 16'h0) begin
            errors++;
            $display("FAIL repeat_release_level: got %h, want 0000", key_press);
        end
    endtask

    initial begin
        test_reset;
        test_press;
        test_bounce;
        test_multi_key;
        test_reset_mid;
        test_repeat;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Scans the board's 4x4 matrix keypad and debounces every key.
- Produces two 16-bit vectors for the slot-management stage: `key_press`, the debounced level, and `key_edge`, a one-cycle press pulse.
- Sits directly upstream of the slot-management logic. That logic consumes only one-hot `key_edge[9:1]`, so this block guarantees `key_edge` is zero or one-hot.

Parameters:
- SCAN_DIV, 50000, clk cycles each column is driven before the next column (1 ms at 50 MHz).
- DEBOUNCE_SCANS, 8, consecutive agreeing full-matrix samples needed to change a key's stable state (range 2..15).
- REPEAT_DELAY, 500, full scans a key is held before the first auto-repeat pulse (only with KEY_REPEAT_EN).
- REPEAT_RATE, 100, full scans between later auto-repeat pulses (only with KEY_REPEAT_EN).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active-HIGH (asserted = 1). Name kept as used across the codebase.
- row_in  in  4  keypad row lines, asynchronous, pulled up; 0 = key closed on the driven column.
- col_out  out  4  column drive, active-low one-hot; exactly one bit is 0 at all times after reset.
- key_press  out  16  debounced pressed level; bit index = 4*row + col.
- key_edge  out  16  one-clk pulse on a debounced press, index as `key_press`.
- scan_tick  out  1  one-clk pulse at the end of each full 4-column scan (used for debug/LED).

Behaviour:
- Reset (rst_n=1 at a clk edge):
  - col_out=4'b1110, key_press=0, key_edge=0, scan_tick=0.
  - Divider, debounce counters, synchronizer flops and repeat counters all cleared.
  - Reset mid-scan discards partial counts; no pulse is emitted during or on the cycle after reset.
- Synchronizer: row_in passes through 2 flops before any use.
- Scan FSM:
  - States COL0..COL3; col_out = ~(1<<state).
  - A divider counts 0..SCAN_DIV-1 in each state.
  - At count SCAN_DIV-1, the synchronized rows are latched as raw[4*r+state] for r=0..3, then the FSM advances COL3->COL0 (wrap) and the divider clears.
  - Sampling at the last count guarantees at least SCAN_DIV-2 cycles of settle after the column change.
  - scan_tick pulses on the cycle the COL3 sample is taken.
- Debounce (per key k, evaluated once per scan_tick):
  - If raw[k] differs from key_press[k], cnt[k] increments; otherwise cnt[k] clears.
  - When cnt[k] reaches DEBOUNCE_SCANS-1 while still differing, key_press[k] toggles and cnt[k] clears.
  - Worst-case debounce latency from a stable contact change is DEBOUNCE_SCANS+1 scans.
- Edge generation:
  - A candidate is set for key k on the cycle key_press[k] goes 0->1.
  - key_edge drives the candidate only if exactly one bit of the new key_press is 1.
  - Otherwise, for multiple/ghost keys, key_edge stays 0 for that event. No edge is issued later for the suppressed key, even after the other keys are released.
  - key_edge is registered; it is high exactly one clk, the cycle after the key_press update.
  - Release (1->0) never produces an edge.
- Simultaneous events: if several keys change stable state on the same scan_tick, all key_press bits update together and the one-hot rule above decides any edge.
- Width rules:
  - Divider width clog2(SCAN_DIV).
  - cnt width 4.
  - Repeat counter width clog2(REPEAT_DELAY+1).
  - No arithmetic overflow is permitted; counters saturate or clear as stated.

Optional Feature:
- Macro KEY_REPEAT_EN.
- Defined: while exactly one key is held, a per-block repeat counter counts scan_ticks.
  - At REPEAT_DELAY, and every REPEAT_RATE thereafter, the block re-issues a one-clk key_edge for that key.
  - Any change in key_press clears the repeat counter.
- Not defined: no repeat logic is synthesized; each press yields exactly one key_edge.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3, REPEAT_DELAY=5, REPEAT_RATE=2):
- Reset, no keys held for 10 scans:
  - col_out cycles 1110,1101,1011,0111 with 4 clk per column.
  - scan_tick every 16 clk.
  - key_press=0 and key_edge=0 throughout.
- Hold key row1/col1 (index 5) cleanly:
  - key_press[5]=1 after 3 scan_ticks.
  - key_edge=16'h0020 for exactly 1 clk.
  - No further edges while held (macro off).
- Bounce: toggle the index-5 contact on alternate scans for 6 scans, then hold steady:
  - No edge during the bounce.
  - Single edge after 3 stable scans.
- Hold index 2, then add index 9:
  - Edge 16'h0004 for index 2.
  - key_press becomes 16'h0204 with no edge for index 9.
  - Release both: key_press returns to 0 with no edges.
- Assert rst_n=1 for 1 clk while key 5 is 2 scans into debounce:
  - Outputs return to reset values.
  - With the key still held, the edge appears 3 full scans after reset is released.
- With KEY_REPEAT_EN defined, hold key 7 for 12 scans:
  - Edges for index 7 at debounce, then at +5 scans, +7, +9 and +11.
  - No edges after release.
